// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: grants one requester per cycle and broadcasts its ROB id/value next cycle.
// Optional performance counters are compiled in when CDB_PERF_CNT_EN is defined.
module cdb_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int ROB_ID_WIDTH = 4,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            rdy,
   input  logic                            reset_from_rob_bus,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*ROB_ID_WIDTH-1:0] req_rob_id,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_value,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            cdb_valid,
   output logic [ROB_ID_WIDTH-1:0]         cdb_rob_id,
   output logic [DATA_WIDTH-1:0]           cdb_value
`ifdef CDB_PERF_CNT_EN
  ,output logic [31:0]                     perf_busy_cnt,
   output logic [31:0]                     perf_conflict_cnt
`endif
);

   localparam int                PTR_W     = $clog2(NUM_REQ);
   localparam logic [PTR_W:0]    NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
   localparam logic [PTR_W-1:0]  LAST_IDX  = PTR_W'(NUM_REQ-1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

   logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic                    cdb_valid_q, cdb_valid_d;
   logic [ROB_ID_WIDTH-1:0] cdb_rob_id_q, cdb_rob_id_d;
   logic [DATA_WIDTH-1:0]   cdb_value_q, cdb_value_d;

   logic                    found_s;
   logic                    grant_en_s;
   logic [PTR_W:0]          idx_s;
   logic [PTR_W-1:0]        grant_idx_s;
   logic [ROB_ID_WIDTH-1:0] grant_id_s;
   logic [DATA_WIDTH-1:0]   grant_value_s;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      found_s     = 1'b0;
      grant_idx_s = '0;
      idx_s       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
         if (idx_s >= NUM_REQ_W) begin
            idx_s = idx_s - NUM_REQ_W;
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req_valid[idx_s[PTR_W-1:0]]) begin
            found_s     = 1'b1;
            grant_idx_s = idx_s[PTR_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Grant gating and selection of the winner's id/value
   always_comb begin
      grant_en_s    = found_s & ~rst & rdy & ~reset_from_rob_bus;
      grant_id_s    = '0;
      grant_value_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx_s == PTR_W'(i)) begin
            grant_id_s    = req_rob_id[i*ROB_ID_WIDTH +: ROB_ID_WIDTH];
            grant_value_s = req_value[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            grant_id_s    = grant_id_s;
         end
      end
      if (grant_en_s) begin
         req_ready = ONE_HOT0 << grant_idx_s;
      end else begin
         req_ready = '0;
      end
   end

   // Next-state: stall holds everything, flush kills the broadcast, tag zero is consumed silently
   always_comb begin
      rr_ptr_d     = rr_ptr_q;
      cdb_valid_d  = cdb_valid_q;
      cdb_rob_id_d = cdb_rob_id_q;
      cdb_value_d  = cdb_value_q;
      if (!rdy) begin
         cdb_valid_d = cdb_valid_q;
      end else if (reset_from_rob_bus) begin
         cdb_valid_d = 1'b0;
      end else if (grant_en_s) begin
         rr_ptr_d = (grant_idx_s == LAST_IDX) ? '0 : grant_idx_s + PTR_W'(1);
         if (grant_id_s != '0) begin
            cdb_valid_d  = 1'b1;
            cdb_rob_id_d = grant_id_s;
            cdb_value_d  = grant_value_s;
         end else begin
            cdb_valid_d  = 1'b0;
         end
      end else begin
         cdb_valid_d = 1'b0;
      end
   end

   // Arbiter state and broadcast registers
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q     <= '0;
         cdb_valid_q  <= 1'b0;
         cdb_rob_id_q <= '0;
         cdb_value_q  <= '0;
      end else begin
         rr_ptr_q     <= rr_ptr_d;
         cdb_valid_q  <= cdb_valid_d;
         cdb_rob_id_q <= cdb_rob_id_d;
         cdb_value_q  <= cdb_value_d;
      end
   end

   assign cdb_valid  = cdb_valid_q;
   assign cdb_rob_id = cdb_rob_id_q;
   assign cdb_value  = cdb_value_q;

`ifdef CDB_PERF_CNT_EN
   logic [31:0] perf_busy_q, perf_busy_d;
   logic [31:0] perf_conflict_q, perf_conflict_d;
   logic        multi_s;

   // Busy counts grants; conflict counts contended cycles outside stall/flush
   always_comb begin
      multi_s = ($countones(req_valid) > 32'sd1);
      if (grant_en_s) begin
         perf_busy_d = perf_busy_q + 32'd1;
      end else begin
         perf_busy_d = perf_busy_q;
      end
      if (rdy && !reset_from_rob_bus && multi_s) begin
         perf_conflict_d = perf_conflict_q + 32'd1;
      end else begin
         perf_conflict_d = perf_conflict_q;
      end
   end

   // Counter registers, cleared only by rst
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_busy_q     <= 32'd0;
         perf_conflict_q <= 32'd0;
      end else begin
         perf_busy_q     <= perf_busy_d;
         perf_conflict_q <= perf_conflict_d;
      end
   end

   assign perf_busy_cnt     = perf_busy_q;
   assign perf_conflict_cnt = perf_conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: reset, directed vector table, hand sequences and a random run against a reference model.
module tb_cdb_arbiter;

   localparam int N  = 3;
   localparam int IW = 4;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst, rdy, flush;
   logic [N-1:0]    req_valid;
   logic [N*IW-1:0] req_rob_id;
   logic [N*DW-1:0] req_value;
   logic [N-1:0]    req_ready;
   logic            cdb_valid;
   logic [IW-1:0]   cdb_rob_id;
   logic [DW-1:0]   cdb_value;
`ifdef CDB_PERF_CNT_EN
   logic [31:0]     perf_busy_cnt, perf_conflict_cnt;
`endif

   cdb_arbiter #(.NUM_REQ(N), .ROB_ID_WIDTH(IW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(flush),
      .req_valid(req_valid), .req_rob_id(req_rob_id), .req_value(req_value),
      .req_ready(req_ready), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value)
`ifdef CDB_PERF_CNT_EN
     ,.perf_busy_cnt(perf_busy_cnt), .perf_conflict_cnt(perf_conflict_cnt)
`endif
   );

   int checks = 0;
   int errors = 0;

   // reference model state: current and next
   int            m_ptr, n_ptr;
   bit            m_cv, n_cv;
   logic [IW-1:0] m_id, n_id;
   logic [DW-1:0] m_val, n_val;

   typedef struct {
      bit              rd;
      bit              fl;
      logic [N-1:0]    v;
      logic [N*IW-1:0] ids;
      logic [N-1:0]    exp_ready;
      bit              exp_cv;
      logic [IW-1:0]   exp_id;
      int              exp_src;
   } vec_t;
   vec_t tbl[15];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_grant();
      if (rst || !rdy || flush) return -1;
      for (int k = 0; k < N; k++) begin
         int i;
         i = (m_ptr + k) % N;
         if (req_valid[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_next();
      int g;
      g = model_grant();
      n_ptr = m_ptr; n_cv = m_cv; n_id = m_id; n_val = m_val;
      if (rst) begin
         n_ptr = 0; n_cv = 1'b0; n_id = '0; n_val = '0;
      end else if (!rdy) begin
         n_cv = m_cv;
      end else if (flush) begin
         n_cv = 1'b0;
      end else if (g >= 0) begin
         n_ptr = (g + 1) % N;
         if (req_rob_id[g*IW +: IW] != 0) begin
            n_cv = 1'b1; n_id = req_rob_id[g*IW +: IW]; n_val = req_value[g*DW +: DW];
         end else begin
            n_cv = 1'b0;
         end
      end else begin
         n_cv = 1'b0;
      end
   endtask

   function automatic logic [N*DW-1:0] mkvals(input logic [N*IW-1:0] ids);
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = {16'hC0DE, 8'(i), 4'h0, ids[i*IW +: IW]};
      return r;
   endfunction

   task automatic drive(input bit r, input bit rd, input bit fl, input logic [N-1:0] v,
                        input logic [N*IW-1:0] ids, input logic [N*DW-1:0] vals);
      @(negedge clk);
      rst = r; rdy = rd; flush = fl; req_valid = v; req_rob_id = ids; req_value = vals;
      #1;
   endtask

   task automatic commit();
      model_next();
      @(posedge clk);
      m_ptr = n_ptr; m_cv = n_cv; m_id = n_id; m_val = n_val;
   endtask

   task automatic run_cycle(input bit r, input bit rd, input bit fl, input logic [N-1:0] v,
                            input logic [N*IW-1:0] ids, input logic [N*DW-1:0] vals, input bit chk_data);
      int g;
      drive(r, rd, fl, v, ids, vals);
      g = model_grant();
      check("req_ready", 64'(req_ready), (g >= 0) ? 64'(1) << g : 64'(0));
      check("cdb_valid", 64'(cdb_valid), 64'(m_cv));
      if (m_cv || chk_data) begin
         check("cdb_rob_id", 64'(cdb_rob_id), 64'(m_id));
         check("cdb_value", 64'(cdb_value), 64'(m_val));
      end
      commit();
   endtask

   initial begin
      m_ptr = 0; m_cv = 1'b0; m_id = '0; m_val = '0;
      tbl[0]  = '{1'b1, 1'b0, 3'b111, 12'h321, 3'b001, 1'b0, 4'd0, 0};
      tbl[1]  = '{1'b1, 1'b0, 3'b111, 12'h321, 3'b010, 1'b1, 4'd1, 0};
      tbl[2]  = '{1'b1, 1'b0, 3'b111, 12'h321, 3'b100, 1'b1, 4'd2, 1};
      tbl[3]  = '{1'b1, 1'b0, 3'b111, 12'h321, 3'b001, 1'b1, 4'd3, 2};
      tbl[4]  = '{1'b1, 1'b1, 3'b100, 12'h321, 3'b000, 1'b1, 4'd1, 0};
      tbl[5]  = '{1'b1, 1'b0, 3'b111, 12'h321, 3'b010, 1'b0, 4'd0, 0};
      tbl[6]  = '{1'b1, 1'b0, 3'b010, 12'h351, 3'b010, 1'b1, 4'd2, 1};
      tbl[7]  = '{1'b0, 1'b0, 3'b111, 12'h351, 3'b000, 1'b1, 4'd5, 1};
      tbl[8]  = '{1'b0, 1'b0, 3'b111, 12'h351, 3'b000, 1'b1, 4'd5, 1};
      tbl[9]  = '{1'b0, 1'b0, 3'b111, 12'h351, 3'b000, 1'b1, 4'd5, 1};
      tbl[10] = '{1'b1, 1'b0, 3'b100, 12'h021, 3'b100, 1'b1, 4'd5, 1};
      tbl[11] = '{1'b1, 1'b0, 3'b011, 12'h387, 3'b001, 1'b0, 4'd0, 0};
      tbl[12] = '{1'b1, 1'b0, 3'b011, 12'h387, 3'b010, 1'b1, 4'd7, 0};
      tbl[13] = '{1'b1, 1'b0, 3'b000, 12'h387, 3'b000, 1'b1, 4'd8, 1};
      tbl[14] = '{1'b1, 1'b0, 3'b000, 12'h387, 3'b000, 1'b0, 4'd0, 0};

      // bring the DUT to a known state before any comparison
      drive(1'b1, 1'b1, 1'b0, 3'b111, 12'h321, mkvals(12'h321));
      commit();
      // reset held with all requesters valid
      run_cycle(1'b1, 1'b1, 1'b0, 3'b111, 12'h321, mkvals(12'h321), 1'b1);
      run_cycle(1'b1, 1'b1, 1'b0, 3'b111, 12'h321, mkvals(12'h321), 1'b1);

      // directed table: round-robin, flush, stall, tag zero
      for (int t = 0; t < 15; t++) begin
         drive(1'b0, tbl[t].rd, tbl[t].fl, tbl[t].v, tbl[t].ids, mkvals(tbl[t].ids));
         check($sformatf("tbl%0d_ready", t), 64'(req_ready), 64'(tbl[t].exp_ready));
         check($sformatf("tbl%0d_cdb_valid", t), 64'(cdb_valid), 64'(tbl[t].exp_cv));
         if (tbl[t].exp_cv) begin
            check($sformatf("tbl%0d_cdb_rob_id", t), 64'(cdb_rob_id), 64'(tbl[t].exp_id));
            check($sformatf("tbl%0d_cdb_value", t), 64'(cdb_value),
                  64'({16'hC0DE, 8'(tbl[t].exp_src), 4'h0, tbl[t].exp_id}));
         end
         commit();
      end

      // single requester after reset, then everyone valid shows rr_ptr moved to 2
      run_cycle(1'b1, 1'b1, 1'b0, 3'b000, 12'h000, '0, 1'b0);
      run_cycle(1'b0, 1'b1, 1'b0, 3'b010, 12'h050, {32'h0, 32'hDEADBEEF, 32'h0}, 1'b0);
      run_cycle(1'b0, 1'b1, 1'b0, 3'b111, 12'h654, {32'h3, 32'h2, 32'h1}, 1'b0);
      run_cycle(1'b0, 1'b1, 1'b0, 3'b000, 12'h000, '0, 1'b0);

`ifdef CDB_PERF_CNT_EN
      run_cycle(1'b1, 1'b1, 1'b0, 3'b000, 12'h000, '0, 1'b0);
      for (int c = 0; c < 10; c++) run_cycle(1'b0, 1'b1, 1'b0, 3'b011, 12'h021, mkvals(12'h021), 1'b0);
      #1;
      check("perf_busy_cnt", 64'(perf_busy_cnt), 64'd10);
      check("perf_conflict_cnt", 64'(perf_conflict_cnt), 64'd10);
`endif

      // random traffic against the reference model
      for (int c = 0; c < 400; c++) begin
         logic [N*DW-1:0] rv;
         for (int i = 0; i < N; i++) rv[i*DW +: DW] = $urandom;
         run_cycle($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 9) == 0,
                   N'($urandom), (N*IW)'($urandom), rv, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) among NUM_REQ functional-unit requesters (ALU, load/store buffer, branch unit).
- The CDB is the broadcast path that carries a result's ROB id and value to the reservation stations and the reorder buffer, which later commits it to the register file write port.
- Round-robin arbitration, valid/ready handshake per requester, registered broadcast.
- Honours ROB flush and the global rdy stall.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ROB_ID_WIDTH, 4, ROB entry id width; id 0 is the reserved "no tag" value
DATA_WIDTH, 32, result value width

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
rdy  input  1  global ready; low freezes the block
reset_from_rob_bus  input  1  ROB flush (mispredict)
req_valid  input  NUM_REQ  requester i has a result (bit i)
req_rob_id  input  NUM_REQ*ROB_ID_WIDTH  packed ids, requester i at [i*ROB_ID_WIDTH +: ROB_ID_WIDTH]
req_value  input  NUM_REQ*DATA_WIDTH  packed values, same packing
req_ready  output  NUM_REQ  one-hot grant; handshake completes when valid&ready
cdb_valid  output  1  broadcast valid (registered)
cdb_rob_id  output  ROB_ID_WIDTH  broadcast ROB id
cdb_value  output  DATA_WIDTH  broadcast value

Behaviour:
- Reset (rst high at posedge): cdb_valid=0, cdb_rob_id=0, cdb_value=0, rr_ptr=0. req_ready is combinational and is 0 while rst is high.
- rr_ptr is the highest-priority index. Search order: rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
- Grant: req_ready[i]=1 for the first i in search order with req_valid[i]=1. req_ready is all-zero when rst, reset_from_rob_bus, or !rdy is asserted. At most one bit is set.
- Grants are made every cycle; the CDB never backpressures. A requester is served within NUM_REQ cycles of asserting valid (no starvation).
- Latency: handshake in cycle N; cdb_valid=1 with the granted id/value from cycle N+1 for exactly one cycle, unless another grant follows.
- When a grant to i occurs, at posedge rr_ptr <= (i+1) mod NUM_REQ. With no grant, rr_ptr holds.
- No grant (and rdy=1, no flush): cdb_valid <= 0. cdb_rob_id/cdb_value hold their last values (don't-care).
- Tag zero: a granted request with rob_id==0 is consumed (ready=1, rr_ptr advances) but not broadcast; cdb_valid <= 0 next cycle.
- Flush: reset_from_rob_bus high at posedge gives cdb_valid <= 0, no grant that cycle, rr_ptr holds. An in-flight broadcast registered the previous cycle is still visible during the flush cycle; consumers drop it.
- rdy low: no grants, all registers hold (cdb_valid included). Consumers are gated by rdy.
- Priority of simultaneous events: rst > !rdy > reset_from_rob_bus > normal grant.
- Requesters must hold valid/id/value stable until the handshake, or until a flush, after which they drop valid themselves.

Optional Feature:
- Macro CDB_PERF_CNT_EN.
- Defined: adds outputs perf_busy_cnt [31:0] and perf_conflict_cnt [31:0], both reset to 0 by rst and not cleared by flush.
  - perf_busy_cnt increments each rdy cycle with a grant.
  - perf_conflict_cnt increments each rdy cycle with two or more req_valid bits set while not flushing.
  - Both wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: rst high 2 cycles with all req_valid=1 -> req_ready=0, cdb_valid=0, id=0, value=0; first cycle after reset grants req 0.
- Single requester: req 1 valid, id=5, value=0xDEADBEEF -> req_ready=3'b010 that cycle; next cycle cdb_valid=1, id=5, value=0xDEADBEEF; rr_ptr=2.
- Round-robin: all three valid continuously from rr_ptr=0 -> grants 0,1,2,0,... each for one cycle; broadcasts follow with 1-cycle lag and no idle cycle.
- Flush: req 2 valid in the same cycle as reset_from_rob_bus -> req_ready=0; next cycle cdb_valid=0; rr_ptr unchanged.
- Stall and tag-zero: rdy low 3 cycles with cdb_valid=1 -> outputs frozen, no grants. Then a req with id=0 -> ready=1, next-cycle cdb_valid=0.
- CDB_PERF_CNT_EN: 10 cycles with 2 requesters valid -> perf_busy_cnt=10, perf_conflict_cnt=10.
